// File: rtl/control_banda_filtro.sv
// Band-select sequencer for the filter output mux: debounced button steps the band,
// and every change goes through a strobe-aligned mute window so recursive filters never click.
module control_banda_filtro #(
  parameter int DB_W          = 20,
  parameter int DB_CICLOS     = 500000,
  parameter int MUTE_W        = 3,
  parameter int MUTE_MUESTRAS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       boton,
  input  logic       muestra_lista,
  output logic [1:0] sel,
  output logic [1:0] banda_activa,
  output logic       cambiando
);

  typedef enum logic [1:0] {
    REPOSO        = 2'd0,
    APAGA         = 2'd1,
    SILENCIO_PEND = 2'd2,
    SILENCIO      = 2'd3
  } estado_t;

  localparam logic [DB_W-1:0]   DB_ULTIMO   = DB_W'(DB_CICLOS - 1);
  localparam logic [MUTE_W-1:0] MUTE_ULTIMO = MUTE_W'(MUTE_MUESTRAS - 1);

  logic              sync1_q, sync2_q;
  logic              nivel_q, nivel_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic              pulso_q, pulso_d;
  estado_t           estado_q, estado_d;
  logic [1:0]        banda_q, banda_d;
  logic [MUTE_W-1:0] cnt_q, cnt_d;
  logic [1:0]        sel_q, sel_d;
  logic [1:0]        banda_sig;

  // Debounce: the level only flips after DB_CICLOS consecutive cycles of disagreement.
  always_comb begin
    nivel_d  = nivel_q;
    db_cnt_d = '0;
    pulso_d  = 1'b0;
    if (sync2_q == nivel_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_ULTIMO) begin
      nivel_d  = sync2_q;
      pulso_d  = sync2_q;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  assign banda_sig = banda_q + 2'd1;

  // A pulse always wins over a strobe in the same cycle; the strobe is simply dropped.
  always_comb begin
    estado_d = estado_q;
    banda_d  = banda_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    if (pulso_q) begin
      banda_d = banda_sig;
      if (banda_sig == 2'b00) begin
        estado_d = APAGA;
      end else if (estado_q == SILENCIO) begin
        estado_d = SILENCIO;
        cnt_d    = '0;
      end else begin
        estado_d = SILENCIO_PEND;
      end
    end else if (muestra_lista) begin
      case (estado_q)
        REPOSO: begin
          estado_d = REPOSO;
        end
        APAGA: begin
          sel_d    = 2'b00;
          estado_d = REPOSO;
        end
        SILENCIO_PEND: begin
          sel_d    = 2'b00;
          cnt_d    = '0;
          estado_d = SILENCIO;
        end
        SILENCIO: begin
          if (cnt_q == MUTE_ULTIMO) begin
            sel_d    = banda_q;
            estado_d = REPOSO;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          estado_d = REPOSO;
        end
      endcase
    end else begin
      estado_d = estado_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      nivel_q  <= 1'b0;
      db_cnt_q <= '0;
      pulso_q  <= 1'b0;
      estado_q <= REPOSO;
      banda_q  <= 2'b00;
      cnt_q    <= '0;
      sel_q    <= 2'b00;
    end else begin
      sync1_q  <= boton;
      sync2_q  <= sync1_q;
      nivel_q  <= nivel_d;
      db_cnt_q <= db_cnt_d;
      pulso_q  <= pulso_d;
      estado_q <= estado_d;
      banda_q  <= banda_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
    end
  end

  assign sel          = sel_q;
  assign banda_activa = banda_q;
  assign cambiando    = (estado_q != REPOSO);

endmodule

// File: tb/tb_control_banda_filtro.sv
// Scoreboard bench for control_banda_filtro with short debounce and mute settings.
module tb_control_banda_filtro;

  typedef struct packed {
    logic [1:0] sel;
    logic [1:0] banda;
    logic       camb;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       boton;
  logic       muestra_lista;
  logic [1:0] sel;
  logic [1:0] banda_activa;
  logic       cambiando;

  exp_t sb_q[$];
  int   tests_run;
  int   tests_failed;

  control_banda_filtro #(
    .DB_W(4),
    .DB_CICLOS(4),
    .MUTE_W(3),
    .MUTE_MUESTRAS(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .boton(boton),
    .muestra_lista(muestra_lista),
    .sel(sel),
    .banda_activa(banda_activa),
    .cambiando(cambiando)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One sample period: seven quiet cycles then a single-cycle strobe.
  task automatic drive_strobe();
    repeat (7) tick();
    muestra_lista = 1'b1;
    tick();
    muestra_lista = 1'b0;
  endtask

  // Hold the button until just before the edge that advances the band.
  task automatic press_to_pulse(input logic strobe_with_pulse);
    boton = 1'b1;
    repeat (6) tick();
    muestra_lista = strobe_with_pulse;
    tick();
    muestra_lista = 1'b0;
  endtask

  task automatic release_button();
    repeat (3) tick();
    boton = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tests_run++;
    if ({sel, banda_activa, cambiando} !== 5'b00000) begin
      tests_failed++;
      $display("FAIL reset_state: got sel=%b banda=%b camb=%b, want 00 00 0", sel, banda_activa, cambiando);
    end
    for (int i = 0; i < 2; i++) sb_q.push_back(exp_t'{sel: 2'b00, banda: 2'b00, camb: 1'b0});
    while (sb_q.size() > 0) begin
      drive_strobe();
      e = sb_q.pop_front();
      tests_run++;
      if ({sel, banda_activa, cambiando} !== e) begin
        tests_failed++;
        $display("FAIL idle_strobe: got sel=%b banda=%b camb=%b, want %b %b %b",
                 sel, banda_activa, cambiando, e.sel, e.banda, e.camb);
      end
    end
  endtask

  task automatic test_short_glitch();
    boton = 1'b1;
    repeat (3) tick();
    boton = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      tests_run++;
      if ({banda_activa, cambiando} !== 3'b000) begin
        tests_failed++;
        $display("FAIL short_glitch: cycle %0d got banda=%b camb=%b, want 00 0", i, banda_activa, cambiando);
      end
    end
  endtask

  task automatic test_first_press();
    exp_t e;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    boton = 1'b1;
    repeat (6) tick();
    tests_run++;
    if ({sel, banda_activa, cambiando} !== 5'b00000) begin
      tests_failed++;
      $display("FAIL press_latency_early: got sel=%b banda=%b camb=%b, want 00 00 0", sel, banda_activa, cambiando);
    end
    tick();
    tests_run++;
    if ({sel, banda_activa, cambiando} !== 5'b00011) begin
      tests_failed++;
      $display("FAIL press_latency: got sel=%b banda=%b camb=%b, want 00 01 1", sel, banda_activa, cambiando);
    end
    release_button();
    sb_q.push_back(exp_t'{sel: 2'b00, banda: 2'b01, camb: 1'b1});
    sb_q.push_back(exp_t'{sel: 2'b00, banda: 2'b01, camb: 1'b1});
    sb_q.push_back(exp_t'{sel: 2'b01, banda: 2'b01, camb: 1'b0});
    while (sb_q.size() > 0) begin
      drive_strobe();
      e = sb_q.pop_front();
      tests_run++;
      if ({sel, banda_activa, cambiando} !== e) begin
        tests_failed++;
        $display("FAIL first_press_strobe: got sel=%b banda=%b camb=%b, want %b %b %b",
                 sel, banda_activa, cambiando, e.sel, e.banda, e.camb);
      end
    end
  endtask

  // Four full presses from band 01; the first also fires a strobe on the pulse cycle.
  task automatic test_sequence();
    exp_t       e;
    logic [1:0] tgt;
    logic [1:0] prev_sel;
    tgt      = 2'b01;
    prev_sel = 2'b01;
    for (int p = 0; p < 4; p++) begin
      tgt = tgt + 2'd1;
      sb_q.push_back(exp_t'{sel: prev_sel, banda: tgt, camb: 1'b1});
      press_to_pulse(p == 0);
      e = sb_q.pop_front();
      tests_run++;
      if ({sel, banda_activa, cambiando} !== e) begin
        tests_failed++;
        $display("FAIL seq_pulse%0d: got sel=%b banda=%b camb=%b, want %b %b %b",
                 p, sel, banda_activa, cambiando, e.sel, e.banda, e.camb);
      end
      release_button();
      if (tgt == 2'b00) begin
        sb_q.push_back(exp_t'{sel: 2'b00, banda: 2'b00, camb: 1'b0});
      end else begin
        sb_q.push_back(exp_t'{sel: 2'b00, banda: tgt, camb: 1'b1});
        sb_q.push_back(exp_t'{sel: 2'b00, banda: tgt, camb: 1'b1});
        sb_q.push_back(exp_t'{sel: tgt, banda: tgt, camb: 1'b0});
      end
      while (sb_q.size() > 0) begin
        drive_strobe();
        e = sb_q.pop_front();
        tests_run++;
        if ({sel, banda_activa, cambiando} !== e) begin
          tests_failed++;
          $display("FAIL seq_strobe%0d: got sel=%b banda=%b camb=%b, want %b %b %b",
                   p, sel, banda_activa, cambiando, e.sel, e.banda, e.camb);
        end
      end
      prev_sel = tgt;
    end
  endtask

  task automatic test_restart_in_mute();
    exp_t e;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    press_to_pulse(1'b0);
    release_button();
    sb_q.push_back(exp_t'{sel: 2'b00, banda: 2'b01, camb: 1'b1});
    sb_q.push_back(exp_t'{sel: 2'b00, banda: 2'b01, camb: 1'b1});
    while (sb_q.size() > 0) begin
      drive_strobe();
      e = sb_q.pop_front();
      tests_run++;
      if ({sel, banda_activa, cambiando} !== e) begin
        tests_failed++;
        $display("FAIL restart_pre: got sel=%b banda=%b camb=%b, want %b %b %b",
                 sel, banda_activa, cambiando, e.sel, e.banda, e.camb);
      end
    end
    press_to_pulse(1'b0);
    tests_run++;
    if ({sel, banda_activa, cambiando} !== 5'b00101) begin
      tests_failed++;
      $display("FAIL restart_pulse: got sel=%b banda=%b camb=%b, want 00 10 1", sel, banda_activa, cambiando);
    end
    release_button();
    sb_q.push_back(exp_t'{sel: 2'b00, banda: 2'b10, camb: 1'b1});
    sb_q.push_back(exp_t'{sel: 2'b10, banda: 2'b10, camb: 1'b0});
    while (sb_q.size() > 0) begin
      drive_strobe();
      e = sb_q.pop_front();
      tests_run++;
      if ({sel, banda_activa, cambiando} !== e) begin
        tests_failed++;
        $display("FAIL restart_post: got sel=%b banda=%b camb=%b, want %b %b %b",
                 sel, banda_activa, cambiando, e.sel, e.banda, e.camb);
      end
    end
  endtask

  task automatic test_reset_in_mute();
    press_to_pulse(1'b0);
    tests_run++;
    if ({sel, banda_activa, cambiando} !== 5'b10111) begin
      tests_failed++;
      $display("FAIL mute_reset_pulse: got sel=%b banda=%b camb=%b, want 10 11 1", sel, banda_activa, cambiando);
    end
    release_button();
    drive_strobe();
    tests_run++;
    if ({sel, banda_activa, cambiando} !== 5'b00111) begin
      tests_failed++;
      $display("FAIL mute_reset_enter: got sel=%b banda=%b camb=%b, want 00 11 1", sel, banda_activa, cambiando);
    end
    repeat (7) tick();
    reset         = 1'b1;
    muestra_lista = 1'b1;
    tick();
    reset         = 1'b0;
    muestra_lista = 1'b0;
    tests_run++;
    if ({sel, banda_activa, cambiando} !== 5'b00000) begin
      tests_failed++;
      $display("FAIL mute_reset: got sel=%b banda=%b camb=%b, want 00 00 0", sel, banda_activa, cambiando);
    end
    drive_strobe();
    tests_run++;
    if ({sel, banda_activa, cambiando} !== 5'b00000) begin
      tests_failed++;
      $display("FAIL mute_reset_after: got sel=%b banda=%b camb=%b, want 00 00 0", sel, banda_activa, cambiando);
    end
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    reset         = 1'b1;
    boton         = 1'b0;
    muestra_lista = 1'b0;
    test_reset();
    test_short_glitch();
    test_first_press();
    test_sequence();
    test_restart_in_mute();
    test_reset_in_mute();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
